// File: rtl/inst_stage_sequencer_pkg.sv
// rtl/inst_stage_sequencer_pkg.sv - shared constants, types and width helpers for the stage sequencer
//
// Purpose: single home for the instruction encodings that expand into
// multiple micro-stages and for the width rules used by every file.
// Ports: none (package).
package inst_stage_sequencer_pkg;

  localparam int INST_BITS_DEF  = 16;
  localparam int DEPTH_DEF      = 2;
  localparam int MAX_STAGES_DEF = 4;
  localparam int CNT_BITS_DEF   = 8;

  // inst[15:6] of a call-with-source word; it gets a pc+4 push pre-stage.
  localparam logic [9:0] INST_CALL_SRC_PREFIX = 10'b0010000001;
  localparam int         CALL_SRC_STAGES      = 2;

  typedef enum logic [0:0] {
    INST_PLAIN    = 1'b0,
    INST_CALL_SRC = 1'b1
  } inst_class_e;

  // Stage index width; kept at least one bit wide.
  function automatic int stage_bits(input int max_stages);
    return (max_stages > 1) ? $clog2(max_stages) : 1;
  endfunction

  // Width able to hold a stage count of up to max_stages.
  function automatic int nstage_bits(input int max_stages);
    return $clog2(max_stages + 1);
  endfunction

  function automatic int occ_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/inst_stage_sequencer_if.sv
// rtl/inst_stage_sequencer_if.sv - fetch/scheduler-side signal bundle of the stage sequencer
//
// Purpose: groups the prefetch push, scheduler handshake, flush and status
// signals. master = prefetch/scheduler side, slave = sequencer.
// Ports: none (parameters INST_BITS, DEPTH, MAX_STAGES, CNT_BITS size the signals).
import inst_stage_sequencer_pkg::*;

interface inst_stage_sequencer_if #(
  parameter int INST_BITS  = INST_BITS_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int MAX_STAGES = MAX_STAGES_DEF,
  parameter int CNT_BITS   = CNT_BITS_DEF
) ();

  localparam int STAGE_BITS = stage_bits(MAX_STAGES);
  localparam int OCC_BITS   = occ_bits(DEPTH);

  logic                  inst_in_valid;
  logic [INST_BITS-1:0]  inst_in;
  logic                  inst_in_ready;
  logic                  uop_valid;
  logic [INST_BITS-1:0]  uop_inst;
  logic [STAGE_BITS-1:0] uop_stage;
  logic                  uop_first;
  logic                  uop_last;
  logic                  push_pc_plus4;
  logic                  uop_done;
  logic                  sched_next_imm_data;
  logic                  next_imm_data;
  logic                  flush;
  logic [OCC_BITS-1:0]   occupancy;
  logic [CNT_BITS-1:0]   retired_count;

  modport master (
    output inst_in_valid, inst_in, uop_done, sched_next_imm_data, flush,
    input  inst_in_ready, uop_valid, uop_inst, uop_stage, uop_first, uop_last,
           push_pc_plus4, next_imm_data, occupancy, retired_count
  );

  modport slave (
    input  inst_in_valid, inst_in, uop_done, sched_next_imm_data, flush,
    output inst_in_ready, uop_valid, uop_inst, uop_stage, uop_first, uop_last,
           push_pc_plus4, next_imm_data, occupancy, retired_count
  );

endinterface

// File: rtl/inst_stage_sequencer_stage_count.sv
// rtl/inst_stage_sequencer_stage_count.sv - combinational instruction-prefix to micro-stage count decoder
//
// Purpose: maps the opcode prefix of the head word to its number of
// micro-stages (1..MAX_STAGES). New multi-stage encodings go here only.
// Ports: i_prefix (inst[15:6]), o_n_stages (stage count), o_is_call (call-src word).
import inst_stage_sequencer_pkg::*;

module inst_stage_count #(
  parameter  int MAX_STAGES = MAX_STAGES_DEF,
  localparam int NS_BITS    = nstage_bits(MAX_STAGES)
) (
  input  logic [9:0]         i_prefix,
  output logic [NS_BITS-1:0] o_n_stages,
  output logic               o_is_call
);

  inst_class_e w_class;
  int          w_raw;

  always_comb begin
    w_class = INST_PLAIN;
    if (i_prefix == INST_CALL_SRC_PREFIX) begin
      w_class = INST_CALL_SRC;
    end

    w_raw = 1;
    case (w_class)
      INST_CALL_SRC: w_raw = CALL_SRC_STAGES;
      default:       w_raw = 1;
    endcase

    if (w_raw > MAX_STAGES) begin
      w_raw = MAX_STAGES;
    end
  end

  assign o_n_stages = NS_BITS'(w_raw);
  assign o_is_call  = (w_class == INST_CALL_SRC);

endmodule

// File: rtl/inst_stage_sequencer.sv
// rtl/inst_stage_sequencer.sv - queued, flushable expander of instruction words into micro-stages
//
// Purpose: circular queue of fetched words between prefetch and the
// decoder/scheduler; the head word is stepped through its micro-stages on
// uop_done and popped (and counted) after its last stage.
// Ports: clk, reset (sync, active-high), bus (slave side of inst_stage_sequencer_if:
// push handshake, head/stage presentation, imm gating, flush, occupancy, retired count).
import inst_stage_sequencer_pkg::*;

module inst_stage_sequencer #(
  parameter int INST_BITS  = INST_BITS_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int MAX_STAGES = MAX_STAGES_DEF,
  parameter int CNT_BITS   = CNT_BITS_DEF
) (
  input logic                   clk,
  input logic                   reset,
  inst_stage_sequencer_if.slave bus
);

  localparam int STAGE_BITS = stage_bits(MAX_STAGES);
  localparam int NS_BITS    = nstage_bits(MAX_STAGES);
  localparam int OCC_BITS   = occ_bits(DEPTH);
  localparam int PTR_BITS   = ptr_bits(DEPTH);

  logic [INST_BITS-1:0]  r_mem [DEPTH];
  logic [PTR_BITS-1:0]   r_rd_ptr;
  logic [PTR_BITS-1:0]   r_wr_ptr;
  logic [OCC_BITS-1:0]   r_occ;
  logic [STAGE_BITS-1:0] r_stage;
  logic [CNT_BITS-1:0]   r_retired;

  logic [INST_BITS-1:0]  w_head;
  logic [NS_BITS-1:0]    w_n_stages;
  logic                  w_is_call;
  logic                  w_valid;
  logic                  w_ready;
  logic                  w_last;
  logic                  w_push;
  logic                  w_done;
  logic                  w_pop;
  logic [PTR_BITS-1:0]   w_rd_inc;
  logic [PTR_BITS-1:0]   w_wr_inc;
  logic [PTR_BITS-1:0]   w_rd_next;

  assign w_head  = r_mem[r_rd_ptr];
  assign w_valid = (r_occ != '0);
  // Ready looks at registered occupancy only: a pop while full does not
  // admit a word in the same cycle.
  assign w_ready = (r_occ != OCC_BITS'(DEPTH));

  inst_stage_count #(
    .MAX_STAGES (MAX_STAGES)
  ) u_stage_count (
    .i_prefix   (w_head[INST_BITS-1 -: 10]),
    .o_n_stages (w_n_stages),
    .o_is_call  (w_is_call)
  );

  assign w_last = (NS_BITS'(r_stage) + NS_BITS'(1)) == w_n_stages;

  // A word arriving with flush is discarded along with the queued tail.
  assign w_push = bus.inst_in_valid && w_ready && !bus.flush;
  assign w_done = bus.uop_done && w_valid;
  assign w_pop  = w_done && w_last;

  assign w_rd_inc  = (r_rd_ptr == PTR_BITS'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_BITS'(1);
  assign w_wr_inc  = (r_wr_ptr == PTR_BITS'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_BITS'(1);
  assign w_rd_next = w_pop ? w_rd_inc : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_occ     <= '0;
      r_stage   <= '0;
      r_retired <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.inst_in;
      end

      r_rd_ptr <= w_rd_next;

      if (bus.flush) begin
        // Only the presented head survives, unless it finishes this cycle.
        if (w_valid && !w_pop) begin
          r_occ    <= OCC_BITS'(1);
          r_wr_ptr <= w_rd_inc;
        end else begin
          r_occ    <= '0;
          r_wr_ptr <= w_rd_next;
        end
      end else begin
        if (w_push) begin
          r_wr_ptr <= w_wr_inc;
        end
        if (w_push && !w_pop) begin
          r_occ <= r_occ + OCC_BITS'(1);
        end else if (!w_push && w_pop) begin
          r_occ <= r_occ - OCC_BITS'(1);
        end
      end

      // Stage wraps to 0 only on the last stage, so it never saturates.
      if (w_pop) begin
        r_stage   <= '0;
        r_retired <= r_retired + CNT_BITS'(1);
      end else if (w_done) begin
        r_stage <= r_stage + STAGE_BITS'(1);
      end
    end
  end

  assign bus.inst_in_ready = w_ready;
  assign bus.uop_valid     = w_valid;
  assign bus.uop_inst      = w_valid ? w_head : '0;
  assign bus.uop_stage     = r_stage;
  assign bus.uop_first     = w_valid && (r_stage == '0);
  assign bus.uop_last      = w_valid && w_last;
  assign bus.push_pc_plus4 = w_valid && w_is_call && (r_stage == '0);
  // Imm data belongs to the final stage; pre-stages never consume it.
  assign bus.next_imm_data = bus.sched_next_imm_data && w_valid && w_last;
  assign bus.occupancy     = r_occ;
  assign bus.retired_count = r_retired;

endmodule

// File: tb/tb_inst_stage_sequencer.sv
// tb/tb_inst_stage_sequencer.sv - directed-vector bench for inst_stage_sequencer
import inst_stage_sequencer_pkg::*;

module tb_inst_stage_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  inst_stage_sequencer_if #(
    .INST_BITS(16), .DEPTH(2), .MAX_STAGES(4), .CNT_BITS(2)
  ) bus ();

  inst_stage_sequencer #(
    .INST_BITS(16), .DEPTH(2), .MAX_STAGES(4), .CNT_BITS(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.inst_in_valid = 1'b0;
    bus.inst_in = 16'h0;
    bus.uop_done = 1'b0;
    bus.sched_next_imm_data = 1'b1;
    bus.flush = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    n_vec++; if (bus.uop_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.uop_valid); end
    n_vec++; if (bus.inst_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", bus.inst_in_ready); end
    n_vec++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy); end
    n_vec++; if (bus.retired_count !== 2'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", bus.retired_count); end
    n_vec++; if (bus.uop_stage !== 2'd0) begin n_fail++; $display("FAIL reset_stage: got %0d want 0", bus.uop_stage); end
    n_vec++; if ({bus.uop_first, bus.uop_last, bus.push_pc_plus4, bus.next_imm_data} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %04b want 0000", {bus.uop_first, bus.uop_last, bus.push_pc_plus4, bus.next_imm_data});
    end
    bus.sched_next_imm_data = 1'b0;
  endtask

  task automatic test_single();
    bus.inst_in_valid = 1'b1;
    bus.inst_in = 16'h8123;
    step();
    bus.inst_in_valid = 1'b0;
    n_vec++; if (bus.uop_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", bus.uop_valid); end
    n_vec++; if (bus.uop_inst !== 16'h8123) begin n_fail++; $display("FAIL single_inst: got %h want 8123", bus.uop_inst); end
    n_vec++; if ({bus.uop_first, bus.uop_last, bus.push_pc_plus4} !== 3'b110) begin
      n_fail++; $display("FAIL single_flags: got %03b want 110", {bus.uop_first, bus.uop_last, bus.push_pc_plus4});
    end
    bus.sched_next_imm_data = 1'b1;
    #1;
    n_vec++; if (bus.next_imm_data !== 1'b1) begin n_fail++; $display("FAIL single_imm: got %0b want 1", bus.next_imm_data); end
    bus.sched_next_imm_data = 1'b0;
    bus.uop_done = 1'b1;
    step();
    bus.uop_done = 1'b0;
    n_vec++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL single_occ: got %0d want 0", bus.occupancy); end
    n_vec++; if (bus.retired_count !== 2'd1) begin n_fail++; $display("FAIL single_retired: got %0d want 1", bus.retired_count); end
  endtask

  task automatic test_call();
    bus.inst_in_valid = 1'b1;
    bus.inst_in = 16'h2045;
    step();
    bus.inst_in_valid = 1'b0;
    bus.sched_next_imm_data = 1'b1;
    #1;
    n_vec++; if ({bus.uop_first, bus.uop_last, bus.push_pc_plus4} !== 3'b101) begin
      n_fail++; $display("FAIL call_s0_flags: got %03b want 101", {bus.uop_first, bus.uop_last, bus.push_pc_plus4});
    end
    n_vec++; if (bus.next_imm_data !== 1'b0) begin n_fail++; $display("FAIL call_s0_imm: got %0b want 0", bus.next_imm_data); end
    bus.uop_done = 1'b1;
    step();
    bus.uop_done = 1'b0;
    n_vec++; if (bus.uop_stage !== 2'd1) begin n_fail++; $display("FAIL call_s1_stage: got %0d want 1", bus.uop_stage); end
    n_vec++; if ({bus.uop_first, bus.uop_last, bus.push_pc_plus4} !== 3'b010) begin
      n_fail++; $display("FAIL call_s1_flags: got %03b want 010", {bus.uop_first, bus.uop_last, bus.push_pc_plus4});
    end
    n_vec++; if (bus.next_imm_data !== 1'b1) begin n_fail++; $display("FAIL call_s1_imm_on: got %0b want 1", bus.next_imm_data); end
    bus.sched_next_imm_data = 1'b0;
    #1;
    n_vec++; if (bus.next_imm_data !== 1'b0) begin n_fail++; $display("FAIL call_s1_imm_off: got %0b want 0", bus.next_imm_data); end
    n_vec++; if (bus.occupancy !== 2'd1) begin n_fail++; $display("FAIL call_s1_occ: got %0d want 1", bus.occupancy); end
    bus.uop_done = 1'b1;
    step();
    bus.uop_done = 1'b0;
    n_vec++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL call_pop_occ: got %0d want 0", bus.occupancy); end
    n_vec++; if (bus.retired_count !== 2'd2) begin n_fail++; $display("FAIL call_pop_retired: got %0d want 2", bus.retired_count); end
    n_vec++; if (bus.uop_stage !== 2'd0) begin n_fail++; $display("FAIL call_pop_stage: got %0d want 0", bus.uop_stage); end
  endtask

  task automatic test_back_to_back();
    bus.inst_in_valid = 1'b1;
    bus.inst_in = 16'h1111;
    step();
    n_vec++; if (bus.inst_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %0b want 1", bus.inst_in_ready); end
    bus.inst_in = 16'h2222;
    step();
    n_vec++; if ({bus.inst_in_ready, bus.occupancy} !== 3'b0_10) begin
      n_fail++; $display("FAIL b2b_full: got ready=%0b occ=%0d want ready=0 occ=2", bus.inst_in_ready, bus.occupancy);
    end
    bus.inst_in = 16'h3333;
    step();
    n_vec++; if (bus.occupancy !== 2'd2 || bus.uop_inst !== 16'h1111) begin
      n_fail++; $display("FAIL b2b_held: got occ=%0d head=%h want occ=2 head=1111", bus.occupancy, bus.uop_inst);
    end
    bus.uop_done = 1'b1;
    #1;
    n_vec++; if (bus.inst_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_same_cycle: got %0b want 0", bus.inst_in_ready); end
    step();
    bus.uop_done = 1'b0;
    n_vec++; if ({bus.inst_in_ready, bus.occupancy} !== 3'b1_01 || bus.uop_inst !== 16'h2222) begin
      n_fail++; $display("FAIL b2b_after_pop: got ready=%0b occ=%0d head=%h want ready=1 occ=1 head=2222", bus.inst_in_ready, bus.occupancy, bus.uop_inst);
    end
    n_vec++; if (bus.retired_count !== 2'd3) begin n_fail++; $display("FAIL b2b_retired_a: got %0d want 3", bus.retired_count); end
    step();
    bus.inst_in_valid = 1'b0;
    n_vec++; if (bus.occupancy !== 2'd2) begin n_fail++; $display("FAIL b2b_c_in: got %0d want 2", bus.occupancy); end
    bus.uop_done = 1'b1;
    step();
    bus.uop_done = 1'b0;
    n_vec++; if (bus.uop_inst !== 16'h3333 || bus.retired_count !== 2'd0) begin
      n_fail++; $display("FAIL b2b_order_c: got head=%h retired=%0d want head=3333 retired=0", bus.uop_inst, bus.retired_count);
    end
    bus.uop_done = 1'b1;
    step();
    bus.uop_done = 1'b0;
    n_vec++; if (bus.occupancy !== 2'd0 || bus.retired_count !== 2'd1) begin
      n_fail++; $display("FAIL b2b_drain: got occ=%0d retired=%0d want occ=0 retired=1", bus.occupancy, bus.retired_count);
    end
  endtask

  task automatic test_flush();
    bus.inst_in_valid = 1'b1;
    bus.inst_in = 16'h1111;
    step();
    bus.inst_in = 16'h2222;
    step();
    bus.inst_in_valid = 1'b0;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    n_vec++; if (bus.occupancy !== 2'd1 || bus.uop_inst !== 16'h1111 || bus.uop_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_keep_head: got occ=%0d head=%h valid=%0b want occ=1 head=1111 valid=1", bus.occupancy, bus.uop_inst, bus.uop_valid);
    end
    n_vec++; if (bus.inst_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b want 1", bus.inst_in_ready); end
    bus.inst_in_valid = 1'b1;
    bus.inst_in = 16'h2222;
    step();
    bus.inst_in_valid = 1'b0;
    n_vec++; if (bus.occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_refill: got %0d want 2", bus.occupancy); end
    bus.flush = 1'b1;
    bus.uop_done = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.uop_done = 1'b0;
    n_vec++; if (bus.occupancy !== 2'd0 || bus.uop_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_with_pop: got occ=%0d valid=%0b want occ=0 valid=0", bus.occupancy, bus.uop_valid);
    end
    n_vec++; if (bus.retired_count !== 2'd2) begin n_fail++; $display("FAIL flush_pop_retired: got %0d want 2", bus.retired_count); end
  endtask

  task automatic test_flush_push();
    bus.inst_in_valid = 1'b1;
    bus.inst_in = 16'h1111;
    step();
    bus.inst_in = 16'h3333;
    bus.flush = 1'b1;
    step();
    bus.inst_in_valid = 1'b0;
    bus.flush = 1'b0;
    n_vec++; if (bus.occupancy !== 2'd1 || bus.uop_inst !== 16'h1111) begin
      n_fail++; $display("FAIL flush_push_drop: got occ=%0d head=%h want occ=1 head=1111", bus.occupancy, bus.uop_inst);
    end
    bus.uop_done = 1'b1;
    step();
    bus.uop_done = 1'b0;
    n_vec++; if (bus.occupancy !== 2'd0 || bus.uop_valid !== 1'b0 || bus.retired_count !== 2'd3) begin
      n_fail++; $display("FAIL flush_push_empty: got occ=%0d valid=%0b retired=%0d want 0 0 3", bus.occupancy, bus.uop_valid, bus.retired_count);
    end
  endtask

  task automatic test_done_idle();
    bus.uop_done = 1'b1;
    step();
    step();
    bus.uop_done = 1'b0;
    n_vec++; if (bus.retired_count !== 2'd3 || bus.uop_stage !== 2'd0 || bus.occupancy !== 2'd0) begin
      n_fail++; $display("FAIL done_idle: got retired=%0d stage=%0d occ=%0d want 3 0 0", bus.retired_count, bus.uop_stage, bus.occupancy);
    end
  endtask

  task automatic test_reset_mid();
    bus.inst_in_valid = 1'b1;
    bus.inst_in = 16'h2045;
    step();
    bus.inst_in_valid = 1'b0;
    bus.uop_done = 1'b1;
    step();
    bus.uop_done = 1'b0;
    n_vec++; if (bus.uop_stage !== 2'd1) begin n_fail++; $display("FAIL rstmid_pre_stage: got %0d want 1", bus.uop_stage); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++; if (bus.occupancy !== 2'd0 || bus.uop_stage !== 2'd0 || bus.retired_count !== 2'd0 || bus.uop_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_clear: got occ=%0d stage=%0d retired=%0d valid=%0b want 0 0 0 0", bus.occupancy, bus.uop_stage, bus.retired_count, bus.uop_valid);
    end
  endtask

  task automatic test_counter_wrap();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      bus.inst_in_valid = 1'b1;
      bus.inst_in = 16'h8123 + 16'(i);
      step();
      bus.inst_in_valid = 1'b0;
      bus.uop_done = 1'b1;
      step();
      bus.uop_done = 1'b0;
      n_vec++; if (bus.retired_count !== exp_seq[i]) begin
        n_fail++; $display("FAIL wrap_retired[%0d]: got %0d want %0d", i, bus.retired_count, exp_seq[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_call();
    test_back_to_back();
    test_flush();
    test_flush_push();
    test_done_idle();
    test_reset_mid();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_stage_sequencer.md
Name: inst_stage_sequencer

Overview:
- Sits between the instruction prefetch buffer and the decoder/scheduler pair.
- Queues fetched 16-bit instruction words and expands each one into 1..MAX_STAGES micro-stages, e.g. the call pre-stage that pushes pc+4.
- Exposes the stage index, first/last flags and imm-data gating to the scheduler.
- Replaces the single hard-wired pre-stage bit with a counted, queued, flushable sequencer.

Parameters:
- INST_BITS, 16, instruction word width.
- DEPTH, 2, instruction queue entries (power of two, >=1).
- MAX_STAGES, 4, maximum micro-stages per instruction (>=2).
- CNT_BITS, 8, width of retired-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inst_in_valid  in  1  fetched word available
- inst_in  in  INST_BITS  fetched word
- inst_in_ready  out  1  queue can accept (= !full)
- uop_valid  out  1  head instruction presented to scheduler
- uop_inst  out  INST_BITS  head instruction word
- uop_stage  out  $clog2(MAX_STAGES)  current stage index
- uop_first  out  1  uop_stage == 0
- uop_last  out  1  uop_stage == n_stages-1
- push_pc_plus4  out  1  call pre-stage active
- uop_done  in  1  scheduler finished current stage (pulse)
- sched_next_imm_data  in  1  scheduler wants next imm chunk
- next_imm_data  out  1  gated imm consumption
- flush  in  1  discard queued, not-yet-presented instructions
- occupancy  out  $clog2(DEPTH)+1  entries held
- retired_count  out  CNT_BITS  instructions completed, wraps

Behaviour:
- Reset: queue empty, stage=0, retired_count=0, uop_valid=0, inst_in_ready=1, occupancy=0, all other outputs 0.
- Push when inst_in_valid && inst_in_ready. Circular buffer with rd/wr pointers wrapping at DEPTH.
- No same-cycle bypass. A word pushed into an empty queue at cycle N gives uop_valid=1 at N+1.
- inst_in_ready depends on registered occupancy only. When full, a simultaneous pop does not open ready in that cycle.
- uop_valid = occupancy != 0. uop_inst = head entry.
- n_stages is computed combinationally from the head word by sub-module inst_stage_count:
  - inst[15:6] == 10'b0010000001 (call src) -> 2.
  - All other encodings -> 1.
  - Results are clamped to MAX_STAGES.
- push_pc_plus4 = uop_valid && inst[15:6]==10'b0010000001 && uop_stage==0.
- next_imm_data = sched_next_imm_data && uop_valid && uop_last. Imm data is never consumed in a pre-stage.
- uop_done while uop_valid:
  - If not last: stage increments; head stays.
  - If last: head pops, stage <= 0, retired_count increments (mod 2^CNT_BITS).
- uop_done while !uop_valid is ignored.
- flush:
  - Drops every entry except the head; the head is already presented to the scheduler and always completes.
  - If flush and uop_done-last occur in the same cycle, the head pops too, leaving the queue empty, and retired_count still increments.
  - A word pushed in the same cycle as flush is discarded. inst_in_ready is unchanged.
  - stage is unaffected unless the head pops.
- Reset mid-instruction: stage, queue and counter clear immediately. No uop_done is expected afterwards.
- Stage counter saturation cannot occur: it wraps to 0 only on the last stage.

Decomposition:
- Shared package/common.vh gets the INST_CALL_SRC_PREFIX (10'b0010000001) constant and the STAGE_BITS localparam rule $clog2(MAX_STAGES).
- One sub-module, inst_stage_count: combinational, word -> n_stages. New multi-stage encodings are added there only.
- Queue storage and pointers stay inline.

Test Plan:
- Reset then push 16'h8123 (cycle 0) -> uop_valid=1 at cycle 1, uop_first=uop_last=1, push_pc_plus4=0. Pulse uop_done -> occupancy 0, retired_count=1.
- Push call 16'h2045 -> stage 0: push_pc_plus4=1, uop_last=0; sched_next_imm_data=1 gives next_imm_data=0. After uop_done -> stage 1, uop_last=1, next_imm_data follows sched_next_imm_data. Second uop_done -> pop, retired_count +1.
- DEPTH=2: push 3 words back-to-back with no uop_done -> inst_in_ready=0 after 2 accepted, third held by source. uop_done-last with valid third word -> ready returns the following cycle; order preserved.
- Queue [A,B] with A in stage 0: flush -> occupancy=1, A still presented. Flush + uop_done-last of A together -> occupancy=0.
- Flush with simultaneous push of C into [A] -> C dropped, occupancy=1.
- CNT_BITS=2: retire 5 instructions -> retired_count sequence 1,2,3,0,1. Reset during stage 1 of a call -> next cycle occupancy=0, uop_stage=0, retired_count=0.
